// File: rtl/ulpi_pkg.sv
// rtl/ulpi_pkg.sv - shared types and helpers for the ULPI PHY reset sequencer
//
// Contents:
//   seq_state_t      sequencer states (RESET_PHY, SETTLE, WAIT_DIR, RUN, FAULT)
//   ULPI_CLK_HZ      nominal ULPI PHY clock
//   cycles_from_us() converts a duration in microseconds to ULPI clock cycles
//   max3()           largest of three integers, used to size the down-counter
package ulpi_pkg;

    localparam int ULPI_CLK_HZ = 60_000_000;

    typedef enum logic [2:0] {
        RESET_PHY = 3'd0,
        SETTLE    = 3'd1,
        WAIT_DIR  = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } seq_state_t;

    function automatic int cycles_from_us(input int us);
        return (ULPI_CLK_HZ / 1_000_000) * us;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ulpi_phy_reset_seq_if.sv
// rtl/ulpi_phy_reset_seq_if.sv - link-side ULPI direction / drive-enable bundle
//
// Signals:
//   ulpi_dir_i      ULPI dir from the PHY
//   ulpi_data_oe_o  link may drive ulpi_data
//   turnaround_o    dir changed this cycle
// Modports:
//   slave   the sequencer (consumes dir, produces oe/turnaround)
//   master  the PHY side / environment (produces dir)
interface ulpi_phy_reset_seq_if;

    logic ulpi_dir_i;
    logic ulpi_data_oe_o;
    logic turnaround_o;

    modport slave (
        input  ulpi_dir_i,
        output ulpi_data_oe_o,
        output turnaround_o
    );

    modport master (
        output ulpi_dir_i,
        input  ulpi_data_oe_o,
        input  turnaround_o
    );

endinterface

// File: rtl/ulpi_bus_turnaround.sv
// rtl/ulpi_bus_turnaround.sv - dir history register, turnaround flag and link drive enable
//
// Ports:
//   clk_i           ULPI PHY clock
//   rst_i           asynchronous active-high reset
//   ulpi_dir_i      ULPI dir from the PHY
//   core_rst_i      core reset; link never drives while it is high
//   turnaround_o    dir differs from its value at the previous edge (combinational)
//   ulpi_data_oe_o  link may drive ulpi_data (combinational)
module ulpi_bus_turnaround (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ulpi_dir_i,
    input  logic core_rst_i,
    output logic turnaround_o,
    output logic ulpi_data_oe_o
);

    logic dir_q;
    logic dir_d;

    assign dir_d = ulpi_dir_i;

    // Resets to 1 so the link assumes the PHY owns the bus until proven otherwise.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dir_q <= 1'b1;
        end else begin
            dir_q <= dir_d;
        end
    end

    assign turnaround_o = ulpi_dir_i ^ dir_q;

    // Requiring dir_q low as well keeps the link off the bus for the
    // turnaround cycle right after the PHY releases it.
    assign ulpi_data_oe_o = !ulpi_dir_i && !dir_q && !core_rst_i;

endmodule

// File: rtl/ulpi_phy_reset_seq.sv
// rtl/ulpi_phy_reset_seq.sv - ULPI PHY bring-up sequencer with dir qualification and turnaround tracking
//
// Optional feature macro: ULPI_RST_WATCHDOG_EN (WAIT_DIR timeout, retry counting, FAULT state).
// Without it the sequencer waits in WAIT_DIR indefinitely and fault_o / retry_count_o are 0.
//
// Ports:
//   clk_i          ULPI PHY clock (60 MHz)
//   rst_i          asynchronous active-high reset
//   soft_reset_i   single-cycle request to rerun the full sequence
//   ulpi           ulpi_phy_reset_seq_if.slave: ulpi_dir_i in, ulpi_data_oe_o / turnaround_o out
//   phy_reset_o    PHY reset, active level set by PHY_RST_ACTIVE_LOW
//   core_rst_o     active-high reset to the core
//   ready_o        sequencer in RUN
//   fault_o        retries exhausted
//   retry_count_o  attempts that timed out, saturating at 3
module ulpi_phy_reset_seq
    import ulpi_pkg::*;
#(
    parameter int PHY_RST_CYCLES     = cycles_from_us(1),
    parameter int SETTLE_CYCLES      = cycles_from_us(100),
    parameter int DIR_TIMEOUT        = cycles_from_us(1000),
    parameter int MAX_RETRIES        = 3,
    parameter int PHY_RST_ACTIVE_LOW = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  soft_reset_i,
    ulpi_phy_reset_seq_if.slave   ulpi,
    output logic                  phy_reset_o,
    output logic                  core_rst_o,
    output logic                  ready_o,
    output logic                  fault_o,
    output logic [1:0]            retry_count_o
);

    localparam int CNT_MAX = max3(PHY_RST_CYCLES, SETTLE_CYCLES, DIR_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] PHY_LOAD    = CNT_W'(PHY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIR_LOAD    = CNT_W'(DIR_TIMEOUT - 1);

    seq_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             low_seen_q, low_seen_d;

    logic phy_reset_q, phy_reset_d;
    logic core_rst_q, core_rst_d;
    logic ready_q, ready_d;

`ifdef ULPI_RST_WATCHDOG_EN
    localparam int ATT_W = $clog2(MAX_RETRIES + 1);
    logic [ATT_W-1:0] att_q, att_d;
    logic             fault_q, fault_d;
`endif

    // State register; outputs are registered from the next state so they
    // change on the same edge as the state they describe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RESET_PHY;
            cnt_q       <= PHY_LOAD;
            low_seen_q  <= 1'b0;
            phy_reset_q <= 1'b1;
            core_rst_q  <= 1'b1;
            ready_q     <= 1'b0;
`ifdef ULPI_RST_WATCHDOG_EN
            att_q       <= '0;
            fault_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            low_seen_q  <= low_seen_d;
            phy_reset_q <= phy_reset_d;
            core_rst_q  <= core_rst_d;
            ready_q     <= ready_d;
`ifdef ULPI_RST_WATCHDOG_EN
            att_q       <= att_d;
            fault_q     <= fault_d;
`endif
        end
    end

    // Next-state logic. The counter only decrements down to zero and is
    // reloaded on state entry, so it never wraps.
    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        // Remembers that dir was low at the previous WAIT_DIR edge.
        low_seen_d = (state_q == WAIT_DIR) && !ulpi.ulpi_dir_i;
`ifdef ULPI_RST_WATCHDOG_EN
        att_d      = att_q;
`endif
        if (soft_reset_i) begin
            state_d = RESET_PHY;
            cnt_d   = PHY_LOAD;
`ifdef ULPI_RST_WATCHDOG_EN
            att_d   = '0;
`endif
        end else begin
            case (state_q)
                RESET_PHY: begin
                    if (cnt_q == '0) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = WAIT_DIR;
                        cnt_d   = DIR_LOAD;
                    end
                end
                WAIT_DIR: begin
                    // A qualified dir wins over a timeout on the same edge.
                    if (!ulpi.ulpi_dir_i && low_seen_q) begin
                        state_d = RUN;
                    end
`ifdef ULPI_RST_WATCHDOG_EN
                    else if (cnt_q == '0) begin
                        att_d = att_q + 1'b1;
                        if (int'(att_q) + 1 == MAX_RETRIES) begin
                            state_d = FAULT;
                        end else begin
                            state_d = RESET_PHY;
                            cnt_d   = PHY_LOAD;
                        end
                    end
`endif
                end
                RUN: begin
                    state_d = RUN;
                end
`ifdef ULPI_RST_WATCHDOG_EN
                FAULT: begin
                    state_d = FAULT;
                end
`endif
                default: begin
                    state_d = RESET_PHY;
                    cnt_d   = PHY_LOAD;
                end
            endcase
        end
    end

    // Output decode from the next state.
    always_comb begin
        phy_reset_d = (state_d == RESET_PHY) || (state_d == FAULT);
        core_rst_d  = (state_d != RUN);
        ready_d     = (state_d == RUN);
`ifdef ULPI_RST_WATCHDOG_EN
        fault_d     = (state_d == FAULT);
`endif
    end

    assign phy_reset_o = phy_reset_q ^ (PHY_RST_ACTIVE_LOW != 0);
    assign core_rst_o  = core_rst_q;
    assign ready_o     = ready_q;

`ifdef ULPI_RST_WATCHDOG_EN
    assign fault_o       = fault_q;
    assign retry_count_o = (int'(att_q) > 3) ? 2'd3 : 2'(att_q);
`else
    assign fault_o       = 1'b0;
    assign retry_count_o = 2'd0;
`endif

    ulpi_bus_turnaround u_turnaround (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ulpi_dir_i     (ulpi.ulpi_dir_i),
        .core_rst_i     (core_rst_q),
        .turnaround_o   (ulpi.turnaround_o),
        .ulpi_data_oe_o (ulpi.ulpi_data_oe_o)
    );

endmodule
